// File: rtl/agc_dsky_pkg.sv
// Shared definitions for the DSKY relay-word receiver.
//   NUM_ROWS / WORD_W / ADDR_W : relay matrix geometry
//   relay_state_e              : receiver FSM states
//   CODE_* / NIB_*             : 5-bit relay digit codes and their display nibbles
package agc_dsky_pkg;
  localparam int unsigned NUM_ROWS = 12;
  localparam int unsigned WORD_W   = 11;
  localparam int unsigned ADDR_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } relay_state_e;

  localparam logic [4:0] CODE_BLANK = 5'b00000;
  localparam logic [4:0] CODE_0     = 5'b10101;
  localparam logic [4:0] CODE_1     = 5'b00011;
  localparam logic [4:0] CODE_2     = 5'b11001;
  localparam logic [4:0] CODE_3     = 5'b11011;
  localparam logic [4:0] CODE_4     = 5'b01111;
  localparam logic [4:0] CODE_5     = 5'b11110;
  localparam logic [4:0] CODE_6     = 5'b11100;
  localparam logic [4:0] CODE_7     = 5'b10011;
  localparam logic [4:0] CODE_8     = 5'b11101;
  localparam logic [4:0] CODE_9     = 5'b11111;

  localparam logic [3:0] NIB_BLANK   = 4'hF;
  localparam logic [3:0] NIB_INVALID = 4'hE;
endpackage

// File: rtl/agc_relay_digit_dec.sv
// Combinational decoder from a 5-bit DSKY relay code to a display nibble.
//   code  : 5-bit relay code (C or D field of a relay row)
//   digit : 0..9, NIB_BLANK for the all-off code, NIB_INVALID otherwise
module agc_relay_digit_dec
  import agc_dsky_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] digit
);
  always_comb begin
    digit = NIB_INVALID;
    case (code)
      CODE_BLANK: digit = NIB_BLANK;
      CODE_0:     digit = 4'd0;
      CODE_1:     digit = 4'd1;
      CODE_2:     digit = 4'd2;
      CODE_3:     digit = 4'd3;
      CODE_4:     digit = 4'd4;
      CODE_5:     digit = 4'd5;
      CODE_6:     digit = 4'd6;
      CODE_7:     digit = 4'd7;
      CODE_8:     digit = 4'd8;
      CODE_9:     digit = 4'd9;
      default:    digit = NIB_INVALID;
    endcase
  end
endmodule

// File: rtl/dsky_relay_rx.sv
// DSKY-side receiver for the channel-10 relay word bus. A word {ADDR,DATA}
// must be held stable for PULLIN edges before it is committed into the
// 12x11 relay image; ADDR 13..15 settle and pulse INVAL without writing.
// Optional feature macro: DSKY_DIGIT_DECODE_EN adds the DIGITS port and the
// 24 relay-code decoders.
// Ports:
//   CLOCK, rst            : clock, asynchronous active-high reset
//   RYWD12..RYWD16        : row address, ADDR = {RYWD16,RYWD14,RYWD13,RYWD12}
//   RLYB01..RLYB11        : row data, DATA = {RLYB11..RLYB01}
//   RLYMAT[131:0]         : relay image, row r at [11*r-1 : 11*(r-1)]
//   LATCH / INVAL         : one-cycle commit / invalid-address pulses
//   BUSY                  : SETTLE or COMMIT
//   DIGITS[95:0]          : (macro only) {C,D} nibbles per row
//   dbg_state[1:0]        : current FSM state
module dsky_relay_rx
  import agc_dsky_pkg::*;
#(
  parameter logic [15:0] PULLIN = 16'd16
) (
  input  logic         CLOCK,
  input  logic         rst,
  input  logic         RYWD12,
  input  logic         RYWD13,
  input  logic         RYWD14,
  input  logic         RYWD16,
  input  logic         RLYB01,
  input  logic         RLYB02,
  input  logic         RLYB03,
  input  logic         RLYB04,
  input  logic         RLYB05,
  input  logic         RLYB06,
  input  logic         RLYB07,
  input  logic         RLYB08,
  input  logic         RLYB09,
  input  logic         RLYB10,
  input  logic         RLYB11,
  output logic [131:0] RLYMAT,
  output logic         LATCH,
  output logic         INVAL,
  output logic         BUSY,
`ifdef DSKY_DIGIT_DECODE_EN
  output logic [95:0]  DIGITS,
`endif
  output logic [1:0]   dbg_state
);
  // SETTLE is entered with CNT = 0 on the first edge of a word, so the move
  // to COMMIT happens on the edge that would make CNT = PULLIN-1; the write
  // then lands one edge later, PULLIN edges after the word was first sampled.
  localparam logic [7:0] PULLIN_M2 = 8'(PULLIN - 16'd2);

  logic [ADDR_W-1:0]        addr_in;
  logic [WORD_W-1:0]        data_in;
  logic [ADDR_W+WORD_W-1:0] in_word;
  logic [ADDR_W-1:0]        samp_addr;
  logic [WORD_W-1:0]        samp_data;
  logic                     changed;
  logic                     addr_nz;

  relay_state_e             state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [ADDR_W+WORD_W-1:0] samp_q, samp_d;
  logic [131:0]             rlymat_q, rlymat_d;
  logic                     latch_q, latch_d;
  logic                     inval_q, inval_d;

  assign addr_in   = {RYWD16, RYWD14, RYWD13, RYWD12};
  assign data_in   = {RLYB11, RLYB10, RLYB09, RLYB08, RLYB07, RLYB06,
                      RLYB05, RLYB04, RLYB03, RLYB02, RLYB01};
  assign in_word   = {addr_in, data_in};
  assign samp_addr = samp_q[ADDR_W+WORD_W-1:WORD_W];
  assign samp_data = samp_q[WORD_W-1:0];
  assign changed   = (in_word != samp_q);
  assign addr_nz   = (addr_in != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    samp_d   = in_word;
    rlymat_d = rlymat_q;
    latch_d  = 1'b0;
    inval_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (changed && addr_nz) begin
          state_d = SETTLE;
          cnt_d   = 8'd0;
        end
      end
      SETTLE: begin
        if (changed) begin
          cnt_d   = 8'd0;
          state_d = addr_nz ? SETTLE : IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == PULLIN_M2) state_d = COMMIT;
        end
      end
      COMMIT: begin
        // The write uses the settled word in SAMP even if the bus moved on.
        if (samp_addr <= 4'(NUM_ROWS)) begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            if (samp_addr == 4'(r + 1)) rlymat_d[r*WORD_W +: WORD_W] = samp_data;
          end
          latch_d = 1'b1;
        end else begin
          inval_d = 1'b1;
        end
        // A new word arriving on this edge starts its settle here, exactly as
        // it would from IDLE.
        cnt_d   = 8'd0;
        state_d = (changed && addr_nz) ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      samp_q   <= '0;
      rlymat_q <= '0;
      latch_q  <= 1'b0;
      inval_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      samp_q   <= samp_d;
      rlymat_q <= rlymat_d;
      latch_q  <= latch_d;
      inval_q  <= inval_d;
    end
  end

  assign RLYMAT    = rlymat_q;
  assign LATCH     = latch_q;
  assign INVAL     = inval_q;
  assign BUSY      = (state_q == SETTLE) || (state_q == COMMIT);
  assign dbg_state = state_q;

`ifdef DSKY_DIGIT_DECODE_EN
  // Row field layout: [10] B, [9:5] C code, [4:0] D code.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    agc_relay_digit_dec u_dec_c (
      .code  (rlymat_q[r*WORD_W+5 +: 5]),
      .digit (DIGITS[r*8+4 +: 4])
    );
    agc_relay_digit_dec u_dec_d (
      .code  (rlymat_q[r*WORD_W +: 5]),
      .digit (DIGITS[r*8 +: 4])
    );
  end
`endif
endmodule

// File: tb/tb_dsky_relay_rx.sv
module tb_dsky_relay_rx;
  localparam int PL = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   addr_drv;
  logic [10:0]  data_drv;
  logic [131:0] rlymat;
  logic         latch, inval, busy;
  logic [1:0]   dbg_state;
`ifdef DSKY_DIGIT_DECODE_EN
  logic [95:0]  digits;
`endif

  dsky_relay_rx #(.PULLIN(16'(PL))) dut (
    .CLOCK  (clk),
    .rst    (rst),
    .RYWD12 (addr_drv[0]),
    .RYWD13 (addr_drv[1]),
    .RYWD14 (addr_drv[2]),
    .RYWD16 (addr_drv[3]),
    .RLYB01 (data_drv[0]),
    .RLYB02 (data_drv[1]),
    .RLYB03 (data_drv[2]),
    .RLYB04 (data_drv[3]),
    .RLYB05 (data_drv[4]),
    .RLYB06 (data_drv[5]),
    .RLYB07 (data_drv[6]),
    .RLYB08 (data_drv[7]),
    .RLYB09 (data_drv[8]),
    .RLYB10 (data_drv[9]),
    .RLYB11 (data_drv[10]),
    .RLYMAT (rlymat),
    .LATCH  (latch),
    .INVAL  (inval),
    .BUSY   (busy),
`ifdef DSKY_DIGIT_DECODE_EN
    .DIGITS (digits),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A word commits on the edge after its PULLIN-th consecutive sample.
  logic [14:0]  m_prev;
  int           m_run;
  bit           m_pend;
  logic [14:0]  m_pend_word;
  logic [131:0] m_img;
  bit           m_latch, m_inval, m_busy;
  logic [14:0]  exp_q[$];
  logic [3:0]   lut[32];

  function automatic logic [95:0] model_digits(input logic [131:0] img);
    logic [95:0] d;
    logic [10:0] row;
    for (int r = 0; r < 12; r++) begin
      row = img[r*11 +: 11];
      d[r*8+4 +: 4] = lut[row[9:5]];
      d[r*8 +: 4]   = lut[row[4:0]];
    end
    return d;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_run = PL + 1; m_pend = 0; m_img = '0;
    m_latch = 0; m_inval = 0; m_busy = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [14:0] w);
    int a;
    m_latch = 0; m_inval = 0;
    if (m_pend) begin
      a = int'(m_pend_word[14:11]);
      if (a <= 12) begin
        m_img[(a-1)*11 +: 11] = m_pend_word[10:0];
        m_latch = 1;
        exp_q.push_back(m_pend_word);
      end else begin
        m_inval = 1;
      end
      m_pend = 0;
    end
    if (w != m_prev) begin
      m_prev = w; m_run = 1;
    end else if (m_run <= PL) begin
      m_run++;
    end
    if (m_prev[14:11] != 0 && m_run == PL) begin
      m_pend = 1; m_pend_word = m_prev;
    end
    m_busy = (m_prev[14:11] != 0) && (m_run <= PL);
  endtask

  // ---------------- driver ----------------
  int cyc = 0;
  int lat_cnt, inv_cnt, busy_cnt, last_lat_cyc;
  bit seen_7ff_row3;

  task automatic clear_counts();
    lat_cnt = 0; inv_cnt = 0; busy_cnt = 0; last_lat_cyc = -1; seen_7ff_row3 = 0;
  endtask

  // Called just after a falling edge; drives, takes one rising edge, checks.
  task automatic cycle(input logic [3:0] a, input logic [10:0] d);
    logic [14:0] e;
    addr_drv = a; data_drv = d;
    @(posedge clk);
    cyc++;
    model_edge({a, d});
    #1;
    check_eq("rlymat", rlymat, m_img);
    check_eq("latch", latch, m_latch);
    check_eq("inval", inval, m_inval);
    check_eq("busy", busy, m_busy);
`ifdef DSKY_DIGIT_DECODE_EN
    check_eq("digits", digits, model_digits(m_img));
`endif
    if (latch) begin
      lat_cnt++; last_lat_cyc = cyc;
      check_eq("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_row", rlymat[(int'(e[14:11])-1)*11 +: 11], e[10:0]);
      end
    end
    if (inval) inv_cnt++;
    if (busy) busy_cnt++;
    if (rlymat[2*11 +: 11] == 11'h7FF) seen_7ff_row3 = 1;
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] a, input logic [10:0] d, input int n);
    for (int i = 0; i < n; i++) cycle(a, d);
  endtask

  // ---------------- test sequence ----------------
  logic [131:0] snap;
  int start_cyc;

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = 4'hE;
    lut[5'b00000] = 4'hF; lut[5'b10101] = 4'd0; lut[5'b00011] = 4'd1;
    lut[5'b11001] = 4'd2; lut[5'b11011] = 4'd3; lut[5'b01111] = 4'd4;
    lut[5'b11110] = 4'd5; lut[5'b11100] = 4'd6; lut[5'b10011] = 4'd7;
    lut[5'b11101] = 4'd8; lut[5'b11111] = 4'd9;

    rst = 1'b1; addr_drv = '0; data_drv = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_eq("rst_rlymat", rlymat, '0);
    check_eq("rst_latch", latch, 0);
    check_eq("rst_inval", inval, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, 0);
`ifdef DSKY_DIGIT_DECODE_EN
    check_eq("rst_digits", digits, {96{1'b1}});
`endif
    rst = 1'b0;

    // Basic commit: row 11, 0x2A3
    clear_counts(); start_cyc = cyc + 1;
    hold(4'd11, 11'h2A3, 20);
    check_eq("basic_latch_cnt", lat_cnt, 1);
    check_eq("basic_latch_edge", last_lat_cyc - start_cyc, PL);
    check_eq("basic_row11", rlymat[10*11 +: 11], 11'h2A3);
`ifdef DSKY_DIGIT_DECODE_EN
    check_eq("basic_digits11", digits[10*8 +: 8], 8'h01);
`endif

    // Glitch restart: row 3 0x7FF for 10 cycles then 0x000
    clear_counts();
    hold(4'd3, 11'h7FF, 10);
    start_cyc = cyc + 1;
    hold(4'd3, 11'h000, 20);
    check_eq("glitch_no_7ff", seen_7ff_row3, 0);
    check_eq("glitch_latch_cnt", lat_cnt, 1);
    check_eq("glitch_latch_edge", last_lat_cyc - start_cyc, PL);
    check_eq("glitch_row3", rlymat[2*11 +: 11], 11'h000);

    // Invalid address 14
    clear_counts(); snap = rlymat;
    hold(4'd14, 11'h155, 24);
    check_eq("inval_cnt", inv_cnt, 1);
    check_eq("inval_no_latch", lat_cnt, 0);
    check_eq("inval_img", rlymat, snap);

    // Idle address with toggling data
    clear_counts(); snap = rlymat;
    for (int i = 0; i < 20; i++) cycle(4'd0, 11'($urandom_range(0, 2047)));
    check_eq("idle_busy_cnt", busy_cnt, 0);
    check_eq("idle_no_latch", lat_cnt, 0);
    check_eq("idle_img", rlymat, snap);

    // Reset mid-settle: row 5 0x3FF, rst at cycle 8
    hold(4'd5, 11'h3FF, 7);
    addr_drv = 4'd5; data_drv = 11'h3FF;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("midrst_rlymat", rlymat, '0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_latch", latch, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_counts(); start_cyc = cyc + 1;
    hold(4'd5, 11'h3FF, 20);
    check_eq("midrst_latch_cnt", lat_cnt, 1);
    check_eq("midrst_latch_edge", last_lat_cyc - start_cyc, PL);
    check_eq("midrst_row5", rlymat[4*11 +: 11], 11'h3FF);

    // Decode coverage: row 1, C=00001 D=00000
    hold(4'd1, 11'h020, 20);
    check_eq("dec_row1", rlymat[10:0], 11'h020);
`ifdef DSKY_DIGIT_DECODE_EN
    check_eq("dec_digits1", digits[7:0], 8'hEF);
`endif

    // Randomized words with random hold lengths around PULLIN
    for (int t = 0; t < 120; t++) begin
      logic [3:0]  ra;
      logic [10:0] rd;
      int          n;
      ra = 4'($urandom_range(0, 15));
      rd = 11'($urandom_range(0, 2047));
      n  = int'($urandom_range(1, PL + 8));
      hold(ra, rd, n);
    end
    hold(4'd0, 11'd0, PL + 2);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety bound on total runtime.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
